modulo_monitor_limite: RTL and testbench

- Sequential alarm controller directly downstream of the 5-bit magnitude comparator. It consumes the comparator's AltB/AeqB/AgtB result, where A is the measured 5-bit level and B is the 5-bit threshold.
- It applies persistence filtering and hysteresis to drive a stable alarm flag, a one-cycle alarm-onset pulse, and a saturating 5-bit alarm event count.
- It flags malformed comparator results, i.e. inputs that are not exactly one-hot.

---
 rtl/modulo_monitor_limite_pkg.sv | 19 +
 rtl/modulo_contador_saturado.sv | 21 ++
 rtl/modulo_monitor_limite.sv | 139 +++++++++++++
 tb/tb_modulo_monitor_limite.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/modulo_monitor_limite_pkg.sv
// Shared constants for the threshold alarm monitor: state encoding,
// default persistence depth and alarm event counter width.
package modulo_monitor_limite_pkg;

   typedef enum logic [1:0] {
      NORMAL   = 2'd0,
      ARMING   = 2'd1,
      ALARM    = 2'd2,
      CLEARING = 2'd3
   } state_t;

   localparam int DEF_PERSIST = 3;
   localparam int EVT_W       = 5;

   function automatic logic one_hot3(input logic a, input logic b, input logic c);
      return ({a, b, c} == 3'b100) || ({a, b, c} == 3'b010) || ({a, b, c} == 3'b001);
   endfunction

endpackage

// File: rtl/modulo_contador_saturado.sv
// Saturating up-counter with synchronous reset; holds at all-ones.
import modulo_monitor_limite_pkg::*;

module modulo_contador_saturado #(
   parameter int W = EVT_W
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         en,
   output logic [W-1:0] cnt
);

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt <= '0;
      end else if (en && (cnt != {W{1'b1}})) begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/modulo_monitor_limite.sv
// Alarm controller fed by a 5-bit magnitude comparator: persistence filter
// with hysteresis, onset pulse, saturating onset count, sticky format error.
import modulo_monitor_limite_pkg::*;

module modulo_monitor_limite #(
   parameter int PERSIST = DEF_PERSIST,
   parameter int CNT_W   = 3
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             sample_en,
   input  logic             AltB,
   input  logic             AeqB,
   input  logic             AgtB,
   input  logic             err_clr,
   output logic             alarm,
   output logic             alarm_rise,
   output logic [EVT_W-1:0] event_cnt,
   output logic [1:0]       state,
   output logic             err
);

   localparam logic [CNT_W-1:0] PERSIST_C = CNT_W'(PERSIST);
   localparam logic [CNT_W-1:0] ONE_C     = CNT_W'(1);

   state_t           st;
   logic [CNT_W-1:0] pcnt;
   logic [CNT_W-1:0] pcnt_inc;
   logic             well_formed;
   logic             valid;
   logic             malformed;
   logic             onset;

   assign well_formed = one_hot3(AltB, AeqB, AgtB);
   assign valid       = sample_en && well_formed;
   assign malformed   = sample_en && !well_formed;
   assign pcnt_inc    = pcnt + 1'b1;

   // Onset only from the non-alarm side; CLEARING->ALARM is a return, not a new event.
   always_comb begin
      onset = 1'b0;
      if (valid && AgtB) begin
         if (st == NORMAL)
            onset = (PERSIST == 1);
         else if (st == ARMING)
            onset = (pcnt_inc == PERSIST_C);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         st         <= NORMAL;
         pcnt       <= '0;
         alarm      <= 1'b0;
         alarm_rise <= 1'b0;
      end else begin
         alarm_rise <= onset;
         if (valid) begin
            case (st)
               NORMAL: begin
                  if (AgtB) begin
                     if (PERSIST == 1) begin
                        st    <= ALARM;
                        alarm <= 1'b1;
                     end else begin
                        st   <= ARMING;
                        pcnt <= ONE_C;
                     end
                  end
               end
               ARMING: begin
                  if (AgtB) begin
                     if (pcnt_inc == PERSIST_C) begin
                        st    <= ALARM;
                        pcnt  <= '0;
                        alarm <= 1'b1;
                     end else begin
                        pcnt <= pcnt_inc;
                     end
                  end else if (AltB) begin
                     st   <= NORMAL;
                     pcnt <= '0;
                  end
               end
               ALARM: begin
                  if (AltB) begin
                     if (PERSIST == 1) begin
                        st    <= NORMAL;
                        alarm <= 1'b0;
                     end else begin
                        st   <= CLEARING;
                        pcnt <= ONE_C;
                     end
                  end
               end
               CLEARING: begin
                  if (AltB) begin
                     if (pcnt_inc == PERSIST_C) begin
                        st    <= NORMAL;
                        pcnt  <= '0;
                        alarm <= 1'b0;
                     end else begin
                        pcnt <= pcnt_inc;
                     end
                  end else if (AgtB) begin
                     st   <= ALARM;
                     pcnt <= '0;
                  end
               end
               default: begin
                  st    <= NORMAL;
                  pcnt  <= '0;
                  alarm <= 1'b0;
               end
            endcase
         end
      end
   end

   // A malformed sample outranks a same-cycle clear.
   always_ff @(posedge clk) begin
      if (reset)
         err <= 1'b0;
      else if (malformed)
         err <= 1'b1;
      else if (err_clr)
         err <= 1'b0;
   end

   assign state = st;

   modulo_contador_saturado #(.W(EVT_W)) u_evt_cnt (
      .clk   (clk),
      .reset (reset),
      .en    (onset),
      .cnt   (event_cnt)
   );

endmodule

// File: tb/tb_modulo_monitor_limite.sv
// Checks two monitors (PERSIST=3 and PERSIST=1) sharing one stimulus stream
// against a behavioural model of the alarm rules.
module tb_modulo_monitor_limite;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic reset, sample_en, AltB, AeqB, AgtB, err_clr;
   logic       alarm_a, rise_a, err_a, alarm_b, rise_b, err_b;
   logic [4:0] evt_a, evt_b;
   logic [1:0] st_a, st_b;

   modulo_monitor_limite #(.PERSIST(3), .CNT_W(3)) u_p3 (
      .clk(clk), .reset(reset), .sample_en(sample_en), .AltB(AltB), .AeqB(AeqB),
      .AgtB(AgtB), .err_clr(err_clr), .alarm(alarm_a), .alarm_rise(rise_a),
      .event_cnt(evt_a), .state(st_a), .err(err_a));

   modulo_monitor_limite #(.PERSIST(1), .CNT_W(3)) u_p1 (
      .clk(clk), .reset(reset), .sample_en(sample_en), .AltB(AltB), .AeqB(AeqB),
      .AgtB(AgtB), .err_clr(err_clr), .alarm(alarm_b), .alarm_rise(rise_b),
      .event_cnt(evt_b), .state(st_b), .err(err_b));

   int tests = 0;
   int fails = 0;

   // Model: st 0..3, run = consecutive qualifying samples toward a crossing.
   int p_val [2] = '{3, 1};
   int m_st  [2];
   int m_run [2];
   int m_ev  [2];
   int m_rise[2];
   int m_err [2];

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic model_edge();
      for (int i = 0; i < 2; i++) begin
         if (reset) begin
            m_st[i] = 0; m_run[i] = 0; m_ev[i] = 0; m_rise[i] = 0; m_err[i] = 0;
         end else begin
            m_rise[i] = 0;
            if (sample_en && (int'(AltB) + int'(AeqB) + int'(AgtB) != 1))
               m_err[i] = 1;
            else if (err_clr)
               m_err[i] = 0;
            if (sample_en && (int'(AltB) + int'(AeqB) + int'(AgtB) == 1)) begin
               if (m_st[i] < 2) begin
                  if (AgtB) begin
                     m_run[i]++;
                     if (m_run[i] == p_val[i]) begin
                        m_st[i] = 2; m_run[i] = 0; m_rise[i] = 1;
                        if (m_ev[i] < 31) m_ev[i]++;
                     end else begin
                        m_st[i] = 1;
                     end
                  end else if (AltB) begin
                     m_st[i] = 0; m_run[i] = 0;
                  end
               end else begin
                  if (AltB) begin
                     m_run[i]++;
                     if (m_run[i] == p_val[i]) begin
                        m_st[i] = 0; m_run[i] = 0;
                     end else begin
                        m_st[i] = 3;
                     end
                  end else if (AgtB) begin
                     m_st[i] = 2; m_run[i] = 0;
                  end
               end
            end
         end
      end
   endtask

   task automatic check_model();
      chk("p3_state", 8'(st_a),    8'(m_st[0]));
      chk("p3_alarm", 8'(alarm_a), 8'(m_st[0] >= 2));
      chk("p3_rise",  8'(rise_a),  8'(m_rise[0]));
      chk("p3_evt",   8'(evt_a),   8'(m_ev[0]));
      chk("p3_err",   8'(err_a),   8'(m_err[0]));
      chk("p1_state", 8'(st_b),    8'(m_st[1]));
      chk("p1_alarm", 8'(alarm_b), 8'(m_st[1] >= 2));
      chk("p1_rise",  8'(rise_b),  8'(m_rise[1]));
      chk("p1_evt",   8'(evt_b),   8'(m_ev[1]));
      chk("p1_err",   8'(err_b),   8'(m_err[1]));
   endtask

   task automatic tick(input bit rs, input bit se, input bit lt, input bit eq,
                       input bit gt, input bit clr);
      reset = rs; sample_en = se; AltB = lt; AeqB = eq; AgtB = gt; err_clr = clr;
      @(posedge clk);
      model_edge();
      #1;
      check_model();
   endtask

   task automatic smp_gt(); tick(0, 1, 0, 0, 1, 0); endtask
   task automatic smp_lt(); tick(0, 1, 1, 0, 0, 0); endtask
   task automatic smp_eq(); tick(0, 1, 0, 1, 0, 0); endtask
   task automatic do_rst(); tick(1, 0, 0, 0, 0, 0); endtask

   initial begin
      reset = 1'b1; sample_en = 1'b0; AltB = 1'b0; AeqB = 1'b0; AgtB = 1'b0; err_clr = 1'b0;
      #2;
      do_rst();
      chk("rst_state", 8'(st_a), 8'd0);
      chk("rst_evt",   8'(evt_a), 8'd0);

      // Persistent AgtB: 1,1,2 with onset on the third edge.
      smp_gt(); chk("arm1", 8'(st_a), 8'd1); chk("arm1_alarm", 8'(alarm_a), 8'd0);
      smp_gt(); chk("arm2", 8'(st_a), 8'd1);
      smp_gt(); chk("arm3", 8'(st_a), 8'd2); chk("arm3_rise", 8'(rise_a), 8'd1);
      chk("arm3_evt", 8'(evt_a), 8'd1);
      tick(0, 0, 0, 0, 1, 0); chk("hold_rise", 8'(rise_a), 8'd0);

      // Clearing then return to alarm without a new onset.
      smp_lt(); chk("clr1", 8'(st_a), 8'd3);
      smp_lt(); chk("clr2", 8'(st_a), 8'd3);
      smp_gt(); chk("back_alarm", 8'(st_a), 8'd2); chk("back_rise", 8'(rise_a), 8'd0);
      chk("back_evt", 8'(evt_a), 8'd1);

      // AeqB holds the count in ARMING.
      do_rst();
      smp_gt(); smp_gt(); smp_eq(); chk("hyst_hold", 8'(st_a), 8'd1);
      smp_gt(); chk("hyst_alarm", 8'(st_a), 8'd2);

      // Malformed inputs and the sticky flag.
      tick(0, 1, 1, 0, 1, 0); chk("bad_err", 8'(err_a), 8'd1); chk("bad_state", 8'(st_a), 8'd2);
      tick(0, 0, 0, 0, 0, 1); chk("errclr", 8'(err_a), 8'd0);
      tick(0, 1, 0, 0, 0, 1); chk("errclr_set_wins", 8'(err_a), 8'd1);
      tick(0, 1, 1, 1, 1, 0);

      // Reset mid-ARMING discards the pending count.
      do_rst();
      smp_gt(); smp_gt();
      do_rst();
      smp_gt(); chk("post_rst_arm", 8'(st_a), 8'd1);
      smp_gt(); chk("post_rst_arm2", 8'(st_a), 8'd1);
      smp_gt(); chk("post_rst_alarm", 8'(st_a), 8'd2);

      // PERSIST=1 instance reacts to a single sample.
      do_rst();
      smp_gt(); chk("p1_one_gt", 8'(st_b), 8'd2); chk("p1_one_rise", 8'(rise_b), 8'd1);
      smp_lt(); chk("p1_one_lt", 8'(st_b), 8'd0);

      // 33 onsets saturate the event counter.
      do_rst();
      for (int k = 0; k < 33; k++) begin
         smp_gt(); smp_gt(); smp_gt();
         smp_lt(); smp_lt(); smp_lt();
      end
      chk("sat_p3", 8'(evt_a), 8'd31);
      chk("sat_p1", 8'(evt_b), 8'd31);

      // Random traffic, biased toward runs so both alarms toggle.
      do_rst();
      for (int k = 0; k < 600; k++) begin
         int r;
         int pat;
         bit lt, eq, gt;
         r = $urandom_range(0, 99);
         if (r < 8) begin
            pat = $urandom_range(0, 4);
            case (pat)
               0: {lt, eq, gt} = 3'b000;
               1: {lt, eq, gt} = 3'b011;
               2: {lt, eq, gt} = 3'b101;
               3: {lt, eq, gt} = 3'b110;
               default: {lt, eq, gt} = 3'b111;
            endcase
         end else if (r < 50) begin
            {lt, eq, gt} = 3'b001;
         end else if (r < 85) begin
            {lt, eq, gt} = 3'b100;
         end else begin
            {lt, eq, gt} = 3'b010;
         end
         tick(($urandom_range(0, 99) < 2), ($urandom_range(0, 9) < 8), lt, eq, gt,
              ($urandom_range(0, 9) < 2));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
